// File: rtl/l1cache_mem_server_pkg.sv
// l1cache_mem_server_pkg: Mem package with line/word types and server FSM states.
package Mem;
  localparam int WORDS_PER_LINE = 4;
  typedef logic [31:0] w_t;
  typedef logic [WORDS_PER_LINE*32-1:0] line_t;
  typedef logic [27:0] lineaddr_t;
  typedef enum logic [1:0] {IDLE, WAIT, WACK, BURST} srv_state_e;
endpackage

// File: rtl/l1cache_mem_if.sv
// l1cache_mem_if: L1-cache-to-memory line request/response bus.
interface l1cache_mem_if;
  import Mem::*;
  logic      req_valid;
  logic      req_we;
  lineaddr_t req_addr;
  line_t     req_data;
  logic      req_ready;
  logic      resp_ack;
  w_t        resp_data;
  modport Server (input req_valid, req_we, req_addr, req_data, output req_ready, resp_ack, resp_data);
  modport Client (output req_valid, req_we, req_addr, req_data, input req_ready, resp_ack, resp_data);
endinterface

// File: rtl/l1cache_mem_server_array.sv
// mem_line_array: single-port line array, synchronous write, combinational read, contents not reset.
module mem_line_array
  import Mem::*;
#(
  parameter int DEPTH_LINES = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_LINES)-1:0] addr,
  input  line_t                          wdata,
  output line_t                          rdata
);
  line_t mem [DEPTH_LINES];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/l1cache_mem_server.sv
// l1cache_mem_server: memory-side responder for l1cache_mem_if with fixed latency and word bursts.
// Define L1CACHE_MEM_SERVER_ASSERT_EN to compile in the request-protocol SVA checks.
module l1cache_mem_server
  import Mem::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 256
) (
  input logic           clk,
  input logic           rst_n,
  l1cache_mem_if.Server bus
);
  localparam int AW = $clog2(DEPTH_LINES);
  localparam int W  = $bits(w_t);
  localparam int BW = $clog2(WORDS_PER_LINE);
  srv_state_e    state_q, state_d;
  logic [7:0]    lat_cnt_q, lat_cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  line_t         wline_q, wline_d, rline_q, rline_d;
  logic          ready_q, ready_d, ack_q, ack_d;
  w_t            data_q, data_d;
  logic          arr_we;
  line_t         arr_rdata;
  mem_line_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (idx_q),
    .wdata (wline_q),
    .rdata (arr_rdata)
  );
  // Outputs are computed from the next state so ack/data are registered yet aligned with WACK/BURST.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wline_d   = wline_q;
    rline_d   = rline_q;
    ack_d     = 1'b0;
    data_d    = '0;
    arr_we    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d   = WAIT;
        lat_cnt_d = 8'(LATENCY - 1);
        we_d      = bus.req_we;
        idx_d     = bus.req_addr[AW-1:0];
        wline_d   = bus.req_data;
      end
      WAIT: if (lat_cnt_q != 8'd0) lat_cnt_d = lat_cnt_q - 8'd1;
      else if (we_q) begin
        state_d = WACK;
        ack_d   = 1'b1;
        arr_we  = 1'b1;
      end else begin
        state_d = BURST;
        beat_d  = '0;
        rline_d = arr_rdata;
        ack_d   = 1'b1;
        data_d  = arr_rdata[W-1:0];
      end
      WACK: state_d = IDLE;
      BURST: if (beat_q == BW'(WORDS_PER_LINE - 1)) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
        ack_d  = 1'b1;
        data_d = rline_q[beat_d*W +: W];
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wline_q   <= '0;
      rline_q   <= '0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wline_q   <= wline_d;
      rline_q   <= rline_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
    end
  assign bus.req_ready = ready_q;
  assign bus.resp_ack  = ack_q;
  assign bus.resp_data = data_q;
`ifdef L1CACHE_MEM_SERVER_ASSERT_EN
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid && !bus.req_ready |=> bus.req_valid);
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid && !bus.req_ready |=> $stable(bus.req_addr) && $stable(bus.req_we) && $stable(bus.req_data));
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid |-> !$isunknown({bus.req_we, bus.req_addr, bus.req_data}));
  a_no_ack_idle: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == IDLE |-> !ack_q);
`endif
endmodule

// File: tb/tb_l1cache_mem_server.sv
// tb_l1cache_mem_server: randomized scoreboard bench for l1cache_mem_server against a line-array model.
module tb_l1cache_mem_server;
  import Mem::*;
  localparam int L   = 4;
  localparam int WPL = WORDS_PER_LINE;
  localparam int W   = $bits(w_t);
  typedef struct {int cyc; w_t d;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  l1cache_mem_if bus();
  l1cache_mem_server #(.LATENCY(L), .DEPTH_LINES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int cyc = 0, busy_end = 0, last_acc = 0, errors = 0, checks = 0;
  exp_t q[$];
  exp_t e;
  line_t ref_mem[int];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response beat must match the oldest expected beat, in data and in cycle.
  always @(negedge clk)
    if (rst_n) begin
      chk("req_ready", bus.req_ready, cyc >= busy_end);
      if (bus.resp_ack) begin
        if (q.size() == 0) chk("unexpected_ack", bus.resp_ack, 1'b0);
        else begin
          e = q.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_data", bus.resp_data, e.d);
        end
      end else chk("idle_data", bus.resp_data, 0);
    end

  task automatic send(input logic we, input lineaddr_t a, input line_t d, input bit junk);
    int n = 0;
    int idx = int'(a % 256);
    bus.req_we = we; bus.req_addr = a; bus.req_data = d; bus.req_valid = 1'b1;
    while (!bus.req_ready) begin
      if (junk) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = lineaddr_t'($urandom);
      end
      @(negedge clk);
      bus.req_we = we; bus.req_addr = a; bus.req_data = d; bus.req_valid = 1'b1;
      if (++n > 300) begin
        $display("FAIL ready_timeout: req_ready still low after %0d cycles", n);
        $fatal(1, "stopping");
      end
    end
    last_acc = cyc + 1;
    if (we) begin
      q.push_back('{cyc: last_acc + L, d: w_t'(0)});
      ref_mem[idx] = d;
      busy_end <= last_acc + L + 1;
    end else begin
      for (int k = 0; k < WPL; k++) q.push_back('{cyc: last_acc + L + k, d: ref_mem[idx][k*W +: W]});
      busy_end <= last_acc + L + WPL;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    line_t l12, l112, rd;
    int n;
    l12  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    l112 = {32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef};
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 28'h12; bus.req_data = l12;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_ack", bus.resp_ack, 1'b0);
    chk("rst_data", bus.resp_data, 0);
    rst_n = 1'b1;
    send(1'b1, 28'h12, l12, 1'b0);
    send(1'b0, 28'h12, '0, 1'b0);
    send(1'b0, 28'h12, '0, 1'b1);
    send(1'b1, 28'h112, l112, 1'b0);
    send(1'b0, 28'h012, '0, 1'b0);
    send(1'b0, 28'h112, '0, 1'b0);
    while (cyc < last_acc + L + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ack", bus.resp_ack, 1'b0);
    chk("abort_ready", bus.req_ready, 1'b1);
    chk("abort_data", bus.resp_data, 0);
    q.delete();
    busy_end = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 28'h12, '0, 1'b0);
    send(1'b0, 28'h112, '0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      lineaddr_t a;
      a = lineaddr_t'({$urandom_range(0, 15), 8'h20 + 8'($urandom_range(0, 7))});
      if (!ref_mem.exists(int'(a % 256)) || $urandom_range(0, 2) == 0) begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        send(1'b1, a, rd, 1'($urandom_range(0, 1)));
      end else send(1'b0, a, '0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
